// File: rtl/vend_engine.sv
// Vending engine: coin credit, per-kind price table, multi-cup purchase and coin change.
// Define VEND_CHANGE_EN to build the CHANGE state (cancel refunds and change payout).
// state_dbg encoding: 0=IDLE 1=CREDIT 2=COST 3=VEND 4=CHANGE.
// Handshakes: coin_valid/price_we/sel_valid/cancel are one-cycle strobes sampled on the rising
// edge; cup_req and change_valid stay high until the matching cup_ack/change_ack edge.
module vend_engine #(
  parameter int NUM_KINDS  = 4,
  parameter int PRICE_W    = 8,
  parameter int CUPS_W     = 3,
  parameter int CREDIT_MAX = 200
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_sel,
  input  logic                         price_we,
  input  logic [$clog2(NUM_KINDS)-1:0] price_idx,
  input  logic [PRICE_W-1:0]           price_data,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_KINDS)-1:0] sel_kind,
  input  logic [CUPS_W-1:0]            sel_cups,
  input  logic                         cancel,
  input  logic                         cup_ack,
  input  logic                         change_ack,
  output logic [PRICE_W-1:0]           credit,
  output logic                         cup_req,
  output logic                         change_valid,
  output logic [1:0]                   change_coin,
  output logic                         coin_reject,
  output logic                         sel_err,
  output logic                         short_funds,
  output logic                         busy,
  output logic                         cfg_ok,
  output logic [2:0]                   state_dbg
);

  localparam int KIND_W = $clog2(NUM_KINDS);
  localparam int COST_W = PRICE_W + CUPS_W;
  localparam logic [KIND_W:0] NK = (KIND_W+1)'(NUM_KINDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CREDIT = 3'd1,
    S_COST   = 3'd2,
    S_VEND   = 3'd3,
    S_CHANGE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PRICE_W-1:0]   price_tab [NUM_KINDS];
  logic [PRICE_W-1:0]   credit_q;
  logic [COST_W-1:0]    cost_q;
  logic [KIND_W-1:0]    kind_q;
  logic [CUPS_W-1:0]    cups_q;
  logic                 coin_reject_q, sel_err_q, short_funds_q;

  logic [PRICE_W-1:0]   coin_amt;
  logic [PRICE_W:0]     coin_sum;
  logic                 coin_fits;
  logic                 kind_ok, sel_ok;
  logic [PRICE_W-1:0]   sel_price;
  logic [COST_W-1:0]    cost_calc;
  logic                 afford;
  logic                 cancel_go;
  logic                 cancel_take;
  logic                 unused_ok;

  always_comb begin
    coin_amt = '0;
    case (coin_sel)
      2'd0: coin_amt = PRICE_W'(1);
      2'd1: coin_amt = PRICE_W'(2);
      2'd2: coin_amt = PRICE_W'(10);
      2'd3: coin_amt = PRICE_W'(20);
      default: coin_amt = '0;
    endcase
  end

  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
  assign coin_fits = coin_sum <= (PRICE_W+1)'(CREDIT_MAX);
  assign kind_ok   = {1'b0, sel_kind} < NK;
  assign sel_price = kind_ok ? price_tab[sel_kind] : '0;
  assign sel_ok    = (sel_cups != '0) && kind_ok && (sel_price != '0);
  // Full-width product so large cup counts can never wrap into an affordable cost.
  assign cost_calc = COST_W'(price_tab[kind_q]) * COST_W'(cups_q);
  assign afford    = COST_W'(credit_q) >= cost_calc;

`ifdef VEND_CHANGE_EN
  logic [PRICE_W-1:0] change_amt;
  logic [1:0]         change_sel;

  always_comb begin
    change_amt = '0;
    change_sel = 2'd0;
    if (credit_q >= PRICE_W'(20)) begin
      change_amt = PRICE_W'(20);
      change_sel = 2'd3;
    end else if (credit_q >= PRICE_W'(10)) begin
      change_amt = PRICE_W'(10);
      change_sel = 2'd2;
    end else if (credit_q >= PRICE_W'(2)) begin
      change_amt = PRICE_W'(2);
      change_sel = 2'd1;
    end else if (credit_q != '0) begin
      change_amt = PRICE_W'(1);
      change_sel = 2'd0;
    end
  end

  assign cancel_go = cancel;
  assign unused_ok = 1'b0;
`else
  assign cancel_go = 1'b0;
  assign unused_ok = &{1'b0, cancel, change_ack};
`endif

  assign cancel_take = cancel_go && (state_q == S_CREDIT || state_q == S_COST);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (coin_valid) state_d = S_CREDIT;
      S_CREDIT: begin
        if (cancel_go)                state_d = S_CHANGE;
        else if (sel_valid && sel_ok) state_d = S_COST;
      end
      S_COST: begin
        if (cancel_go)   state_d = S_CHANGE;
        else if (afford) state_d = S_VEND;
        else             state_d = S_CREDIT;
      end
      S_VEND: begin
        if (cup_ack && cups_q == CUPS_W'(1)) begin
`ifdef VEND_CHANGE_EN
          state_d = S_CHANGE;
`else
          state_d = (COST_W'(credit_q) != cost_q) ? S_CREDIT : S_IDLE;
`endif
        end
      end
      S_CHANGE: begin
`ifdef VEND_CHANGE_EN
        if (credit_q == '0)                           state_d = S_IDLE;
        else if (change_ack && credit_q == change_amt) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: credit, price table, purchase latch and status pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      credit_q      <= '0;
      cost_q        <= '0;
      kind_q        <= '0;
      cups_q        <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      short_funds_q <= 1'b0;
      for (int i = 0; i < NUM_KINDS; i++) price_tab[i] <= '0;
    end else begin
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      short_funds_q <= 1'b0;
      if (coin_valid) begin
        if ((state_q == S_IDLE || state_q == S_CREDIT) && !cancel_take && coin_fits)
          credit_q <= coin_sum[PRICE_W-1:0];
        else
          coin_reject_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (price_we && ({1'b0, price_idx} < NK)) price_tab[price_idx] <= price_data;
        end
        S_CREDIT: begin
          if (sel_valid && !cancel_take) begin
            if (sel_ok) begin
              kind_q <= sel_kind;
              cups_q <= sel_cups;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        S_COST: begin
          cost_q <= cost_calc;
          if (!cancel_take && !afford) short_funds_q <= 1'b1;
        end
        S_VEND: begin
          if (cup_ack) begin
            cups_q <= cups_q - CUPS_W'(1);
            if (cups_q == CUPS_W'(1)) credit_q <= credit_q - cost_q[PRICE_W-1:0];
          end
        end
        S_CHANGE: begin
`ifdef VEND_CHANGE_EN
          if (change_ack && credit_q != '0) credit_q <= credit_q - change_amt;
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy         = (state_q == S_COST) || (state_q == S_VEND) || (state_q == S_CHANGE);
    cup_req      = (state_q == S_VEND);
    change_valid = 1'b0;
    change_coin  = 2'd0;
`ifdef VEND_CHANGE_EN
    if (state_q == S_CHANGE && credit_q != '0) begin
      change_valid = 1'b1;
      change_coin  = change_sel;
    end
`endif
    credit      = credit_q;
    coin_reject = coin_reject_q;
    sel_err     = sel_err_q;
    short_funds = short_funds_q;
    state_dbg   = state_q;
    cfg_ok      = 1'b1;
    for (int i = 0; i < NUM_KINDS; i++)
      if (price_tab[i] == '0) cfg_ok = 1'b0;
  end

endmodule

// File: tb/tb_vend_engine.sv
// Self-checking bench for vend_engine: directed scenarios plus randomized coin and purchase
// runs against a credit/price model; expectations follow VEND_CHANGE_EN when defined.
module tb_vend_engine;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_COST   = 3'd2;
  localparam logic [2:0] S_VEND   = 3'd3;
  localparam logic [2:0] S_CHANGE = 3'd4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = '0;
  logic       price_we = 1'b0;
  logic [1:0] price_idx = '0;
  logic [7:0] price_data = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_kind = '0;
  logic [2:0] sel_cups = '0;
  logic       cancel = 1'b0;
  logic       cup_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic [7:0] credit;
  logic       cup_req, change_valid, coin_reject, sel_err, short_funds, busy, cfg_ok;
  logic [1:0] change_coin;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int price_m [4];

  vend_engine #(.NUM_KINDS(4), .PRICE_W(8), .CUPS_W(3), .CREDIT_MAX(200)) dut (
    .CLK(CLK), .RST_N(RST_N), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .price_we(price_we), .price_idx(price_idx), .price_data(price_data),
    .sel_valid(sel_valid), .sel_kind(sel_kind), .sel_cups(sel_cups), .cancel(cancel),
    .cup_ack(cup_ack), .change_ack(change_ack), .credit(credit), .cup_req(cup_req),
    .change_valid(change_valid), .change_coin(change_coin), .coin_reject(coin_reject),
    .sel_err(sel_err), .short_funds(short_funds), .busy(busy), .cfg_ok(cfg_ok),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference helpers: coin values and largest payable coin
  function automatic int coin_value(input int sel);
    case (sel)
      0: return 1;
      1: return 2;
      2: return 10;
      default: return 20;
    endcase
  endfunction

  function automatic int largest_code(input int c);
    if (c >= 20) return 3;
    if (c >= 10) return 2;
    if (c >= 2)  return 1;
    return 0;
  endfunction

  // Driver tasks: each is entered and left on a falling edge
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic put_coin(input int sel);
    coin_valid = 1'b1;
    coin_sel   = sel[1:0];
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic write_price(input int idx, input int data);
    price_we   = 1'b1;
    price_idx  = idx[1:0];
    price_data = data[7:0];
    tick();
    price_we   = 1'b0;
  endtask

  task automatic select(input int kind, input int cups);
    sel_valid = 1'b1;
    sel_kind  = kind[1:0];
    sel_cups  = cups[2:0];
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic pulse_cup_ack();
    cup_ack = 1'b1;
    tick();
    cup_ack = 1'b0;
  endtask

  task automatic pulse_change_ack();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  task automatic apply_reset();
    coin_valid = 0; price_we = 0; sel_valid = 0; cancel = 0; cup_ack = 0; change_ack = 0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic setup_prices();
    apply_reset();
    price_m[0] = 15; price_m[1] = 25; price_m[2] = 12; price_m[3] = 30;
    for (int i = 0; i < 4; i++) write_price(i, price_m[i]);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({state_dbg, credit, cup_req, change_valid, change_coin, coin_reject, sel_err,
         short_funds, busy, cfg_ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs state=%0d credit=%0d cup_req=%b chg=%b busy=%b cfg_ok=%b exp all 0",
               state_dbg, credit, cup_req, change_valid, busy, cfg_ok);
    end
  endtask

  task automatic test_price_table();
    apply_reset();
    write_price(0, 15); write_price(1, 25); write_price(2, 0); write_price(3, 30);
    n_tests++;
    if (cfg_ok !== 1'b0) begin n_fail++; $display("FAIL cfg_ok_zero_entry got=%b exp=0", cfg_ok); end
    write_price(2, 12);
    n_tests++;
    if (cfg_ok !== 1'b1) begin n_fail++; $display("FAIL cfg_ok_full got=%b exp=1", cfg_ok); end
  endtask

  task automatic test_vend_flow();
    setup_prices();
    put_coin(3); put_coin(3); put_coin(1);
    n_tests++;
    if (credit !== 8'd42 || state_dbg !== S_CREDIT) begin
      n_fail++; $display("FAIL vend_coins credit=%0d state=%0d exp 42/%0d", credit, state_dbg, S_CREDIT);
    end
    select(0, 2);
    n_tests++;
    if (state_dbg !== S_COST || busy !== 1'b1) begin
      n_fail++; $display("FAIL vend_cost state=%0d busy=%b exp %0d/1", state_dbg, busy, S_COST);
    end
    tick();
    n_tests++;
    if (state_dbg !== S_VEND || cup_req !== 1'b1) begin
      n_fail++; $display("FAIL vend_enter state=%0d cup_req=%b exp %0d/1", state_dbg, cup_req, S_VEND);
    end
    put_coin(2);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd42) begin
      n_fail++; $display("FAIL vend_coin_reject rej=%b credit=%0d exp 1/42", coin_reject, credit);
    end
    pulse_cup_ack();
    n_tests++;
    if (credit !== 8'd42 || cup_req !== 1'b1) begin
      n_fail++; $display("FAIL vend_first_ack credit=%0d cup_req=%b exp 42/1", credit, cup_req);
    end
    pulse_cup_ack();
    n_tests++;
    if (credit !== 8'd12 || cup_req !== 1'b0) begin
      n_fail++; $display("FAIL vend_second_ack credit=%0d cup_req=%b exp 12/0", credit, cup_req);
    end
`ifdef VEND_CHANGE_EN
    tick();
    n_tests++;
    if (state_dbg !== S_CHANGE || change_valid !== 1'b1 || change_coin !== 2'd2) begin
      n_fail++; $display("FAIL change_ten state=%0d valid=%b coin=%0d exp %0d/1/2",
                         state_dbg, change_valid, change_coin, S_CHANGE);
    end
    pulse_change_ack();
    n_tests++;
    if (credit !== 8'd2 || change_valid !== 1'b1 || change_coin !== 2'd1) begin
      n_fail++; $display("FAIL change_two credit=%0d valid=%b coin=%0d exp 2/1/1", credit, change_valid, change_coin);
    end
    pulse_change_ack();
    n_tests++;
    if (credit !== 8'd0 || state_dbg !== S_IDLE || change_valid !== 1'b0) begin
      n_fail++; $display("FAIL change_done credit=%0d state=%0d valid=%b exp 0/%0d/0",
                         credit, state_dbg, change_valid, S_IDLE);
    end
`else
    n_tests++;
    if (state_dbg !== S_CREDIT || credit !== 8'd12 || change_valid !== 1'b0 || change_coin !== 2'd0) begin
      n_fail++; $display("FAIL vend_leftover state=%0d credit=%0d chg=%b coin=%0d exp %0d/12/0/0",
                         state_dbg, credit, change_valid, change_coin, S_CREDIT);
    end
`endif
  endtask

  task automatic test_short_funds();
    setup_prices();
    put_coin(2);
    select(1, 1);
    tick();
    n_tests++;
    if (short_funds !== 1'b1 || state_dbg !== S_CREDIT || credit !== 8'd10) begin
      n_fail++; $display("FAIL short_funds sf=%b state=%0d credit=%0d exp 1/%0d/10",
                         short_funds, state_dbg, credit, S_CREDIT);
    end
    tick();
    n_tests++;
    if (short_funds !== 1'b0) begin n_fail++; $display("FAIL short_funds_pulse sf=%b exp 0", short_funds); end
  endtask

  task automatic test_credit_cap();
    setup_prices();
    for (int i = 0; i < 9; i++) put_coin(3);
    put_coin(2);
    n_tests++;
    if (credit !== 8'd190) begin n_fail++; $display("FAIL cap_fill credit=%0d exp 190", credit); end
    put_coin(3);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd190) begin
      n_fail++; $display("FAIL cap_reject rej=%b credit=%0d exp 1/190", coin_reject, credit);
    end
    put_coin(2);
    n_tests++;
    if (coin_reject !== 1'b0 || credit !== 8'd200) begin
      n_fail++; $display("FAIL cap_exact rej=%b credit=%0d exp 0/200", coin_reject, credit);
    end
    put_coin(0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd200) begin
      n_fail++; $display("FAIL cap_full rej=%b credit=%0d exp 1/200", coin_reject, credit);
    end
    write_price(0, 0);
    n_tests++;
    if (cfg_ok !== 1'b1) begin n_fail++; $display("FAIL price_we_outside_idle cfg_ok=%b exp 1", cfg_ok); end
  endtask

  task automatic test_cancel();
    setup_prices();
    put_coin(3); put_coin(0);
    coin_valid = 1'b1; coin_sel = 2'd3; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
`ifdef VEND_CHANGE_EN
    n_tests++;
    if (state_dbg !== S_CHANGE || credit !== 8'd21 || change_valid !== 1'b1 || change_coin !== 2'd3) begin
      n_fail++; $display("FAIL cancel_wins state=%0d credit=%0d valid=%b coin=%0d exp %0d/21/1/3",
                         state_dbg, credit, change_valid, change_coin, S_CHANGE);
    end
    pulse_change_ack();
    n_tests++;
    if (credit !== 8'd1 || change_coin !== 2'd0 || change_valid !== 1'b1) begin
      n_fail++; $display("FAIL cancel_one credit=%0d coin=%0d valid=%b exp 1/0/1", credit, change_coin, change_valid);
    end
    pulse_change_ack();
    n_tests++;
    if (state_dbg !== S_IDLE || credit !== 8'd0) begin
      n_fail++; $display("FAIL cancel_done state=%0d credit=%0d exp %0d/0", state_dbg, credit, S_IDLE);
    end
    put_coin(0);
`else
    n_tests++;
    if (state_dbg !== S_CREDIT || credit !== 8'd41) begin
      n_fail++; $display("FAIL cancel_ignored state=%0d credit=%0d exp %0d/41", state_dbg, credit, S_CREDIT);
    end
`endif
    select(0, 0);
    n_tests++;
    if (sel_err !== 1'b1 || state_dbg !== S_CREDIT) begin
      n_fail++; $display("FAIL sel_zero_cups sel_err=%b state=%0d exp 1/%0d", sel_err, state_dbg, S_CREDIT);
    end
  endtask

  task automatic test_reset_mid_vend();
    setup_prices();
    put_coin(3);
    select(0, 1);
    tick();
    n_tests++;
    if (state_dbg !== S_VEND) begin n_fail++; $display("FAIL midvend_enter state=%0d exp %0d", state_dbg, S_VEND); end
    RST_N = 1'b0;
    #1;
    n_tests++;
    if (state_dbg !== S_IDLE || credit !== 8'd0 || cup_req !== 1'b0 || cfg_ok !== 1'b0) begin
      n_fail++; $display("FAIL midvend_async state=%0d credit=%0d cup_req=%b cfg_ok=%b exp 0/0/0/0",
                         state_dbg, credit, cup_req, cfg_ok);
    end
    tick();
    RST_N = 1'b1;
    pulse_cup_ack();
    n_tests++;
    if (state_dbg !== S_IDLE || credit !== 8'd0 || cup_req !== 1'b0) begin
      n_fail++; $display("FAIL midvend_after state=%0d credit=%0d cup_req=%b exp 0/0/0", state_dbg, credit, cup_req);
    end
  endtask

  task automatic test_exact_vend();
    setup_prices();
    put_coin(2); put_coin(1); put_coin(1); put_coin(0);
    select(0, 1);
    tick();
    pulse_cup_ack();
    n_tests++;
`ifdef VEND_CHANGE_EN
    if (state_dbg !== S_CHANGE || change_valid !== 1'b0 || credit !== 8'd0) begin
      n_fail++; $display("FAIL exact_change_entry state=%0d valid=%b credit=%0d exp %0d/0/0",
                         state_dbg, change_valid, credit, S_CHANGE);
    end
    tick();
    n_tests++;
`endif
    if (state_dbg !== S_IDLE || credit !== 8'd0) begin
      n_fail++; $display("FAIL exact_idle state=%0d credit=%0d exp %0d/0", state_dbg, credit, S_IDLE);
    end
  endtask

  task automatic test_random_coins();
    int m, sel, v;
    logic exp_rej;
    setup_prices();
    m = 0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      v = coin_value(sel);
      exp_rej = (m + v > 200);
      if (!exp_rej) m += v;
      put_coin(sel);
      n_tests++;
      if (credit !== m[7:0] || coin_reject !== exp_rej) begin
        n_fail++; $display("FAIL rand_coin[%0d] credit=%0d rej=%b exp %0d/%b", i, credit, coin_reject, m, exp_rej);
      end
    end
  endtask

  task automatic test_random_purchase();
    int m, sel, v, kind, cups, cost, guard;
    setup_prices();
    m = 0;
    for (int it = 0; it < 15; it++) begin
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
        sel = $urandom_range(0, 3);
        v = coin_value(sel);
        if (m + v <= 200) m += v;
        put_coin(sel);
      end
      kind = $urandom_range(0, 3);
      cups = $urandom_range(1, 7);
      cost = price_m[kind] * cups;
      select(kind, cups);
      tick();
      if (m >= cost) begin
        n_tests++;
        if (cup_req !== 1'b1) begin n_fail++; $display("FAIL rand_vend[%0d] cup_req=%b exp 1 (credit %0d cost %0d)", it, cup_req, m, cost); end
        cup_ack = 1'b1;
        for (int k = 0; k < cups; k++) tick();
        cup_ack = 1'b0;
        m -= cost;
        n_tests++;
        if (credit !== m[7:0] || cup_req !== 1'b0) begin
          n_fail++; $display("FAIL rand_debit[%0d] credit=%0d cup_req=%b exp %0d/0", it, credit, cup_req, m);
        end
`ifdef VEND_CHANGE_EN
        guard = 0;
        while (state_dbg !== S_IDLE && guard < 30) begin
          guard++;
          if (change_valid === 1'b1) begin
            n_tests++;
            if (change_coin !== 2'(largest_code(m))) begin
              n_fail++; $display("FAIL rand_change[%0d] coin=%0d exp %0d", it, change_coin, largest_code(m));
            end
            m -= coin_value(largest_code(m));
            pulse_change_ack();
          end else begin
            tick();
          end
        end
        n_tests++;
        if (state_dbg !== S_IDLE || credit !== 8'd0 || m != 0) begin
          n_fail++; $display("FAIL rand_drain[%0d] state=%0d credit=%0d model=%0d exp idle/0/0", it, state_dbg, credit, m);
        end
`else
        guard = 0;
        n_tests++;
        if (state_dbg !== ((m > 0) ? S_CREDIT : S_IDLE)) begin
          n_fail++; $display("FAIL rand_after_vend[%0d] state=%0d credit_model=%0d", it, state_dbg, m);
        end
`endif
      end else begin
        n_tests++;
        if (short_funds !== 1'b1 || state_dbg !== S_CREDIT || credit !== m[7:0]) begin
          n_fail++; $display("FAIL rand_short[%0d] sf=%b state=%0d credit=%0d exp 1/%0d/%0d (cost %0d)",
                             it, short_funds, state_dbg, credit, S_CREDIT, m, cost);
        end
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_price_table();
    test_vend_flow();
    test_short_funds();
    test_credit_cap();
    test_cancel();
    test_reset_mid_vend();
    test_exact_vend();
    test_random_coins();
    test_random_purchase();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
